e203_ifu_bht: RTL
=================

E203_IFU_BHT -- requirements
Module: e203_ifu_bht

Interface
Parameters:
REQ-001 SHALL have parameter PC_W, default 32, PC width in bits.
REQ-002 SHALL have parameter IDX_W, default 6, table index width; ENTRIES = 2^IDX_W.
REQ-003 SHALL have parameter CTR_INIT, default 2'b01, counter value written at initialization (weakly not-taken).

Ports:
REQ-004 SHALL have clk, input, 1, single clock; all state changes on the rising edge.
REQ-005 SHALL have rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have lkp_valid, input, 1, the IFU mini-decoder flags a conditional branch (Bxx) this cycle.
REQ-007 SHALL have lkp_pc, input, PC_W, PC of the branch being looked up.
REQ-008 SHALL have lkp_taken, output, 1, predicted taken, consumed by the Lite-BPU in the same cycle.
REQ-009 SHALL have ready, output, 1, the table is initialized and predictions are valid.
REQ-010 SHALL have upd_valid, input, 1, EXU commit reports a resolved conditional branch.
REQ-011 SHALL have upd_pc, input, PC_W, PC of the resolved branch.
REQ-012 SHALL have upd_taken, input, 1, actual resolved direction.
REQ-013 SHALL have upd_mis, input, 1, that branch was mispredicted.
REQ-014 SHALL have clr, input, 1, synchronous request to re-initialize the table (e.g. fence.i).
REQ-015 SHALL have mis_cnt, output, 16, saturating count of mispredictions.

Function
REQ-016 SHALL hold ENTRIES 2-bit saturating counters; the entry index is pc[IDX_W:1], so bit 0 is ignored and bit 1 is used for RVC.
REQ-017 SHALL implement FSM states INIT and RUN; ready = (state == RUN).
REQ-018 In INIT, SHALL write CTR_INIT to entry init_ptr each cycle and increment init_ptr (IDX_W bits, starting at 0).
REQ-019 SHALL transition INIT -> RUN on the cycle in which entry ENTRIES-1 is written, so INIT lasts exactly ENTRIES cycles.
REQ-020 In RUN, clr = 1 SHALL transition to INIT with init_ptr = 0 on the next edge.
REQ-021 clr asserted while in INIT SHALL restart initialization at init_ptr = 0.
REQ-022 lkp_taken SHALL be combinational: lkp_valid & ready & ctr[idx(lkp_pc)][1]; lookup latency is 0 cycles.
REQ-023 When upd_valid & ready & ~clr, the counter at idx(upd_pc) SHALL be incremented if upd_taken and decremented otherwise.
REQ-024 Counter saturation: SHALL stay at 2'b11 on a taken update and at 2'b00 on a not-taken update.
REQ-025 An update SHALL be visible to lookups from the cycle after the update edge; there is no bypass, so a same-cycle lookup of the same index sees the old value.
REQ-026 upd_valid while not ready, or in a cycle with clr = 1, SHALL be dropped with no table or mis_cnt change.
REQ-027 mis_cnt SHALL increment by 1 on upd_valid & upd_mis & ready & ~clr, and SHALL saturate at 16'hFFFF.
REQ-028 mis_cnt SHALL NOT be cleared by clr.
REQ-029 Lookup and update in the same cycle SHALL both be serviced; there is no stall and no backpressure.

Reset
REQ-030 rst SHALL force state = INIT, init_ptr = 0 and mis_cnt = 0 at the next edge; ready = 0 and lkp_taken = 0 from that edge onward.
REQ-031 Table contents SHALL need no reset; they are defined only after INIT completes.
REQ-032 rst asserted mid-INIT or mid-RUN SHALL restart the full ENTRIES-cycle initialization.
REQ-033 rst SHALL take priority over clr and upd_valid.

Verification
REQ-034 Bench SHALL cover: release rst with IDX_W = 6 -> ready rises exactly 64 cycles later; lkp_valid = 1 throughout -> lkp_taken = 0 until ready, then 0 (CTR_INIT = 01).
REQ-035 Bench SHALL cover: after ready, 2 taken updates at pc 0x80000010 -> lkp_taken = 1 for pc 0x80000010 and also for alias 0x80000090; pc 0x80000012 (different index) -> 0.
REQ-036 Bench SHALL cover: 5 taken updates then 1 not-taken update at the same pc -> counter 11 -> 10, lkp_taken stays 1; 2 more not-taken updates -> 00, then 1 further not-taken -> stays 00.
REQ-037 Bench SHALL cover: same-cycle lookup and taken update on an entry at 01 -> lkp_taken = 0 that cycle and 1 the next cycle.
REQ-038 Bench SHALL cover: clr pulse in RUN with upd_valid = 1 -> update dropped, ready = 0 for 64 cycles, all entries back to 01, mis_cnt unchanged.
REQ-039 Bench SHALL cover: mis_cnt preloaded by 65535 upd_mis events, one more event -> stays 16'hFFFF; then rst -> mis_cnt = 0.

Source files
------------

// File: rtl/e203_ifu_bht.sv
`default_nettype none
// =============================================================================
// Module   : e203_ifu_bht
// Brief    : Bimodal branch history table of 2-bit saturating counters that
//            feeds a zero-latency taken prediction to the IFU Lite-BPU.
// Revision : 1.0 - initial release
// =============================================================================
module e203_ifu_bht #(
    parameter int         PC_W     = 32,
    parameter int         IDX_W    = 6,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lkp_valid,
    input  logic [PC_W-1:0] lkp_pc,
    output logic            lkp_taken,
    output logic            ready,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic            upd_mis,
    input  logic            clr,
    output logic [15:0]     mis_cnt
);

    localparam int               c_ENTRIES  = 1 << IDX_W;
    localparam logic [IDX_W-1:0] c_LAST_IDX = {IDX_W{1'b1}};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_init_ptr;
    logic [1:0]       r_ctr [c_ENTRIES];
    logic [15:0]      r_mis_cnt;

    logic [IDX_W-1:0] w_lkp_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic             w_init_wr;
    logic             w_upd_en;
    logic [1:0]       w_upd_old;
    logic [1:0]       w_upd_new;
    logic             w_unused;

    // Bit 0 is always zero for legal PCs; bit 1 distinguishes RVC halfwords.
    assign w_lkp_idx = lkp_pc[IDX_W:1];
    assign w_upd_idx = upd_pc[IDX_W:1];
    assign w_unused  = ^{lkp_pc[PC_W-1:IDX_W+1], lkp_pc[0],
                         upd_pc[PC_W-1:IDX_W+1], upd_pc[0]};

    assign ready     = (r_state == ST_RUN);
    assign lkp_taken = lkp_valid & ready & r_ctr[w_lkp_idx][1];
    assign mis_cnt   = r_mis_cnt;

    assign w_init_wr = ~rst & (r_state == ST_INIT);
    assign w_upd_en  = ~rst & upd_valid & ready & ~clr;
    assign w_upd_old = r_ctr[w_upd_idx];

    always_comb begin
        w_upd_new = w_upd_old;
        if (upd_taken) begin
            if (w_upd_old != 2'b11) w_upd_new = w_upd_old + 2'b01;
        end else begin
            if (w_upd_old != 2'b00) w_upd_new = w_upd_old - 2'b01;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (!clr && (r_init_ptr == c_LAST_IDX)) w_state_nxt = ST_RUN;
            ST_RUN:  if (clr) w_state_nxt = ST_INIT;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_INIT;
        else     r_state <= w_state_nxt;
    end

    // The pointer wraps to zero on the last init write, so RUN always holds 0.
    always_ff @(posedge clk) begin
        if (rst || clr)              r_init_ptr <= '0;
        else if (r_state == ST_INIT) r_init_ptr <= r_init_ptr + 1'b1;
    end

    // Table contents are left unreset; INIT defines every entry before use.
    always_ff @(posedge clk) begin
        if (w_init_wr)     r_ctr[r_init_ptr] <= CTR_INIT;
        else if (w_upd_en) r_ctr[w_upd_idx]  <= w_upd_new;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_mis_cnt <= '0;
        else if (w_upd_en && upd_mis && (r_mis_cnt != 16'hFFFF))
            r_mis_cnt <= r_mis_cnt + 16'd1;
    end

endmodule
`default_nettype wire
